// File: rtl/memory_access_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    // funct3 width/sign encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Control bus layout: [0] reg write enable, [1] mem read, [2] mem write, [4:3] writeback select
    localparam int CONTROL_BIT   = 5;
    localparam int CTRL_REGEN    = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;

    // Everything captured from Execute that is carried through to WriteBack
    typedef struct packed {
        logic [31:0]            instr;
        logic [CONTROL_BIT-1:0] control;
        logic [31:0]            alu_result;
        logic [4:0]             rd_addr;
        logic [31:0]            pcplus;
    } op_t;

    // Counter width able to hold the value cyc itself
    function automatic int timeout_width(input int cyc);
        if (cyc < 2) return 1;
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/memory_access_align.sv
// Byte-lane steering: store data/strobe generation, misalignment check, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_data,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    output logic        req_misaligned,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_addr,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] rsp_data
);

    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    // Replicate store data across lanes and strobe only the addressed bytes
    always_comb begin
        req_wdata      = req_data;
        req_wstrb      = 4'hF;
        req_misaligned = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: begin
                req_wdata = {4{req_data[7:0]}};
                req_wstrb = 4'b0001 << req_addr;
            end
            F3_H, F3_HU: begin
                req_wdata      = {2{req_data[15:0]}};
                req_wstrb      = 4'b0011 << req_addr;
                req_misaligned = req_addr[0];
            end
            default: begin
                req_misaligned = |req_addr;
            end
        endcase
    end

    assign rsp_byte = rsp_rdata[{rsp_addr, 3'b000} +: 8];
    assign rsp_half = rsp_rdata[{rsp_addr[1], 4'b0000} +: 16];

    // Pick the addressed byte/half from the returned word and sign/zero-extend it
    always_comb begin
        rsp_data = rsp_rdata;
        case (rsp_funct3)
            F3_B:    rsp_data = {{24{rsp_byte[7]}}, rsp_byte};
            F3_BU:   rsp_data = {24'd0, rsp_byte};
            F3_H:    rsp_data = {{16{rsp_half[15]}}, rsp_half};
            F3_HU:   rsp_data = {16'd0, rsp_half};
            F3_W:    rsp_data = rsp_rdata;
            default: rsp_data = rsp_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: one instruction at a time, runs its load/store on a req/gnt/rvalid bus, hands result to WB.
// Latency: ALU op 1 cycle; store 1 cycle after gnt; load 1 cycle after rvalid; bus timeout after TIMEOUT_CYC.
// Backpressure: single-entry; ex_ready_o only in IDLE or in HOLD when WriteBack takes the result.
module memory_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ex_valid_i,
    output logic                   ex_ready_o,
    input  logic [31:0]            ex_instr_i,
    input  logic [CONTROL_BIT-1:0] ex_control_i,
    input  logic [31:0]            ex_aluResult_i,
    input  logic [31:0]            ex_storeData_i,
    input  logic [4:0]             ex_rd_addr_i,
    input  logic [31:0]            ex_pcplus_i,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [31:0]            dmem_addr_o,
    output logic [31:0]            dmem_wdata_o,
    output logic [3:0]             dmem_wstrb_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [31:0]            dmem_rdata_i,
    output logic                   mem_valid_o,
    input  logic                   mem_ready_i,
    output logic [31:0]            mem_instr_o,
    output logic [CONTROL_BIT-1:0] mem_control_o,
    output logic [31:0]            mem_aluResult_o,
    output logic [31:0]            mem_readData_o,
    output logic [31:0]            mem_pcplus_o,
    output logic [31:0]            mem_rd_addr_o,
    output logic                   exc_misaligned_o,
    output logic                   exc_buserr_o
);

    localparam int               CNT_W   = timeout_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    state_t           state_q, state_d, accept_state;
    op_t              op_q, ex_op;
    logic [31:0]      read_data_q, wdata_q, ex_wdata, load_data;
    logic [3:0]       wstrb_q, ex_wstrb;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             we_q, exc_mis_q, exc_bus_q;
    logic             transfer, ex_is_mem, ex_misaligned, ex_mis_mem;
    logic             timeout_hit, timeout_fire;

    load_store_align u_align (
        .req_funct3     (ex_instr_i[14:12]),
        .req_addr       (ex_aluResult_i[1:0]),
        .req_data       (ex_storeData_i),
        .req_wdata      (ex_wdata),
        .req_wstrb      (ex_wstrb),
        .req_misaligned (ex_misaligned),
        .rsp_funct3     (op_q.instr[14:12]),
        .rsp_addr       (op_q.alu_result[1:0]),
        .rsp_rdata      (dmem_rdata_i),
        .rsp_data       (load_data)
    );

    assign transfer     = ex_valid_i & ex_ready_o;
    assign ex_is_mem    = ex_control_i[CTRL_MEMREAD] | ex_control_i[CTRL_MEMWRITE];
    assign ex_mis_mem   = ex_is_mem & ex_misaligned;
    assign accept_state = (ex_is_mem && !ex_mis_mem) ? REQ : HOLD;
    assign cnt_inc      = cnt_q + CNT_W'(1);
    assign timeout_hit  = (cnt_inc == CNT_MAX);
    // A grant or response in the last allowed cycle still wins over the timeout
    assign timeout_fire = timeout_hit &&
                          ((state_q == REQ && !dmem_gnt_i) || (state_q == RESP && !dmem_rvalid_i));

    // Operand bundle as it will be stored; a dropped misaligned access must not write a register
    always_comb begin
        ex_op.instr      = ex_instr_i;
        ex_op.control    = ex_control_i;
        ex_op.alu_result = ex_aluResult_i;
        ex_op.rd_addr    = ex_rd_addr_i;
        ex_op.pcplus     = ex_pcplus_i;
        if (ex_mis_mem) ex_op.control[CTRL_REGEN] = 1'b0;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (transfer) state_d = accept_state;
            REQ: begin
                if (dmem_gnt_i)       state_d = we_q ? HOLD : RESP;
                else if (timeout_hit) state_d = HOLD;
            end
            RESP: begin
                if (dmem_rvalid_i || timeout_hit) state_d = HOLD;
            end
            HOLD: if (mem_ready_i) state_d = transfer ? accept_state : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus and handshake outputs decoded from the current state
    always_comb begin
        ex_ready_o   = 1'b0;
        mem_valid_o  = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_wstrb_o = '0;
        case (state_q)
            IDLE: ex_ready_o = rst_ni;
            REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_addr_o  = {op_q.alu_result[31:2], 2'b00};
                dmem_wdata_o = wdata_q;
                dmem_wstrb_o = wstrb_q;
            end
            HOLD: begin
                mem_valid_o = 1'b1;
                ex_ready_o  = rst_ni & mem_ready_i;
            end
            default: ;
        endcase
    end

    // Operand capture, load data, timeout counter and exception pulses
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q        <= '0;
            read_data_q <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            exc_mis_q   <= 1'b0;
            exc_bus_q   <= 1'b0;
        end else begin
            exc_mis_q <= transfer & ex_mis_mem;
            exc_bus_q <= timeout_fire;
            if ((state_d == REQ && state_q != REQ) || (state_d == RESP && state_q != RESP))
                cnt_q <= '0;
            else if (state_q == REQ || state_q == RESP)
                cnt_q <= cnt_inc;
            if (transfer) begin
                op_q        <= ex_op;
                read_data_q <= '0;
                we_q        <= ex_control_i[CTRL_MEMWRITE];
                wdata_q     <= ex_wdata;
                wstrb_q     <= ex_wstrb;
            end
            if (state_q == RESP && dmem_rvalid_i) read_data_q <= load_data;
            if (timeout_fire) op_q.control[CTRL_REGEN] <= 1'b0;
        end
    end

    assign mem_instr_o      = op_q.instr;
    assign mem_control_o    = op_q.control;
    assign mem_aluResult_o  = op_q.alu_result;
    assign mem_readData_o   = read_data_q;
    assign mem_pcplus_o     = op_q.pcplus;
    assign mem_rd_addr_o    = {27'd0, op_q.rd_addr};
    assign exc_misaligned_o = exc_mis_q;
    assign exc_buserr_o     = exc_bus_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: ALU streaming, store/load formatting, misalignment, timeout, reset.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: mem_ready_i is dropped in the misaligned scenario to exercise HOLD stalls.
module tb_memory_access;
    import mem_pkg::*;

    localparam logic [31:0] I_ADD = 32'h0000_0033;
    localparam logic [31:0] I_SB  = 32'h0000_0023;
    localparam logic [31:0] I_SW  = 32'h0000_2023;
    localparam logic [31:0] I_LH  = 32'h0000_1003;
    localparam logic [31:0] I_LHU = 32'h0000_5003;
    localparam logic [31:0] I_LW  = 32'h0000_2003;
    localparam logic [CONTROL_BIT-1:0] C_ALU = 5'b01001;
    localparam logic [CONTROL_BIT-1:0] C_LD  = 5'b10011;
    localparam logic [CONTROL_BIT-1:0] C_LDX = 5'b10010;
    localparam logic [CONTROL_BIT-1:0] C_ST  = 5'b00100;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                   rst_ni, ex_valid_i, ex_ready_o;
    logic [31:0]            ex_instr_i, ex_aluResult_i, ex_storeData_i, ex_pcplus_i;
    logic [CONTROL_BIT-1:0] ex_control_i, mem_control_o;
    logic [4:0]             ex_rd_addr_i;
    logic                   dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [31:0]            dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]             dmem_wstrb_o;
    logic                   mem_valid_o, mem_ready_i, exc_misaligned_o, exc_buserr_o;
    logic [31:0]            mem_instr_o, mem_aluResult_o, mem_readData_o, mem_pcplus_o, mem_rd_addr_o;

    int errors = 0;
    int checks = 0;

    memory_access #(.TIMEOUT_CYC(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_instr_i(ex_instr_i), .ex_control_i(ex_control_i),
        .ex_aluResult_i(ex_aluResult_i), .ex_storeData_i(ex_storeData_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_pcplus_i(ex_pcplus_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_instr_o(mem_instr_o), .mem_control_o(mem_control_o),
        .mem_aluResult_o(mem_aluResult_o), .mem_readData_o(mem_readData_o),
        .mem_pcplus_o(mem_pcplus_o), .mem_rd_addr_o(mem_rd_addr_o),
        .exc_misaligned_o(exc_misaligned_o), .exc_buserr_o(exc_buserr_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] instr, input logic [CONTROL_BIT-1:0] ctrl,
                            input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd);
        ex_valid_i     = v;
        ex_instr_i     = instr;
        ex_control_i   = ctrl;
        ex_aluResult_i = alu;
        ex_storeData_i = sdata;
        ex_rd_addr_i   = rd;
        ex_pcplus_i    = alu + 32'd4;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive_ex(1'b1, I_ADD, C_ALU, 32'h55, 32'h0, 5'd1);
        tick(); tick();
        checks++; if ({ex_ready_o, mem_valid_o, dmem_req_o, exc_misaligned_o, exc_buserr_o} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {ex_ready_o, mem_valid_o, dmem_req_o, exc_misaligned_o, exc_buserr_o}); end
        checks++; if (mem_aluResult_o !== 32'h0) begin errors++; $display("FAIL reset_alu: got %h want 0", mem_aluResult_o); end
        checks++; if (mem_control_o !== '0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", mem_control_o); end
        ex_valid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ex_ready_o); end
    endtask

    task automatic test_alu_back_to_back();
        mem_ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_ex(1'b1, I_ADD, C_ALU, 32'(i), 32'h0, 5'd7);
            #1;
            checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL alu_ready[%0d]: got %b want 1", i, ex_ready_o); end
            tick();
            checks++; if (mem_valid_o !== 1'b1 || mem_aluResult_o !== 32'(i)) begin errors++; $display("FAIL alu_result[%0d]: got v=%b %h want v=1 %h", i, mem_valid_o, mem_aluResult_o, 32'(i)); end
            checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL alu_noreq[%0d]: got %b want 0", i, dmem_req_o); end
            checks++; if (mem_rd_addr_o !== 32'd7 || mem_control_o !== C_ALU) begin errors++; $display("FAIL alu_rd_ctrl[%0d]: got rd=%h ctrl=%b want 7 %b", i, mem_rd_addr_o, mem_control_o, C_ALU); end
        end
        checks++; if (mem_pcplus_o !== 32'd7) begin errors++; $display("FAIL alu_pcplus: got %h want 7", mem_pcplus_o); end
        ex_valid_i = 1'b0;
        tick();
        checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL alu_drain: got %b want 0", mem_valid_o); end
    endtask

    task automatic test_store_byte();
        drive_ex(1'b1, I_SB, C_ST, 32'h103, 32'h0000_00AB, 5'd0);
        tick();
        ex_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            dmem_gnt_i = (c == 2);
            #1;
            checks++; if ({dmem_req_o, dmem_we_o, ex_ready_o, mem_valid_o} !== 4'b1100) begin errors++; $display("FAIL sb_req[%0d]: got req/we/rdy/vld=%b want 1100", c, {dmem_req_o, dmem_we_o, ex_ready_o, mem_valid_o}); end
            checks++; if (dmem_addr_o !== 32'h100 || dmem_wdata_o !== 32'hABAB_ABAB || dmem_wstrb_o !== 4'b1000) begin errors++; $display("FAIL sb_bus[%0d]: got %h %h %b want 00000100 abababab 1000", c, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o); end
            tick();
        end
        dmem_gnt_i = 1'b0;
        checks++; if ({mem_valid_o, dmem_req_o, ex_ready_o} !== 3'b101) begin errors++; $display("FAIL sb_hold: got vld/req/rdy=%b want 101", {mem_valid_o, dmem_req_o, ex_ready_o}); end
        checks++; if (mem_control_o !== C_ST || mem_readData_o !== 32'h0) begin errors++; $display("FAIL sb_result: got ctrl=%b rd=%h want %b 0", mem_control_o, mem_readData_o, C_ST); end
        tick();
    endtask

    task automatic test_store_word_fast();
        dmem_gnt_i = 1'b1;
        drive_ex(1'b1, I_SW, C_ST, 32'h104, 32'h1234_5678, 5'd0);
        tick();
        ex_valid_i = 1'b0;
        checks++; if (mem_valid_o !== 1'b0 || dmem_req_o !== 1'b1) begin errors++; $display("FAIL sw_n1: got vld=%b req=%b want 0 1", mem_valid_o, dmem_req_o); end
        checks++; if (dmem_addr_o !== 32'h104 || dmem_wdata_o !== 32'h1234_5678 || dmem_wstrb_o !== 4'hF) begin errors++; $display("FAIL sw_bus: got %h %h %b want 00000104 12345678 1111", dmem_addr_o, dmem_wdata_o, dmem_wstrb_o); end
        tick();
        dmem_gnt_i = 1'b0;
        checks++; if (mem_valid_o !== 1'b1 || dmem_req_o !== 1'b0) begin errors++; $display("FAIL sw_n2: got vld=%b req=%b want 1 0", mem_valid_o, dmem_req_o); end
        tick();
    endtask

    task automatic test_load_half(input logic [31:0] instr, input logic [31:0] expv, input string name);
        drive_ex(1'b1, instr, C_LD, 32'h102, 32'h0, 5'd9);
        tick();
        ex_valid_i = 1'b0;
        checks++; if ({dmem_req_o, dmem_we_o, ex_ready_o} !== 3'b100 || dmem_addr_o !== 32'h100) begin errors++; $display("FAIL %s_req: got req/we/rdy=%b addr=%h want 100 00000100", name, {dmem_req_o, dmem_we_o, ex_ready_o}, dmem_addr_o); end
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        checks++; if (dmem_req_o !== 1'b0 || mem_valid_o !== 1'b0) begin errors++; $display("FAIL %s_resp_wait: got req=%b vld=%b want 0 0", name, dmem_req_o, mem_valid_o); end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h8001_1234;
        tick();
        dmem_rvalid_i = 1'b0;
        checks++; if (mem_valid_o !== 1'b1 || mem_readData_o !== expv) begin errors++; $display("FAIL %s_data: got vld=%b %h want 1 %h", name, mem_valid_o, mem_readData_o, expv); end
        checks++; if (mem_control_o !== C_LD || mem_rd_addr_o !== 32'd9) begin errors++; $display("FAIL %s_ctrl: got %b rd=%h want %b 9", name, mem_control_o, mem_rd_addr_o, C_LD); end
        tick();
    endtask

    task automatic test_misaligned();
        mem_ready_i = 1'b0;
        drive_ex(1'b1, I_LW, C_LD, 32'h101, 32'h0, 5'd3);
        tick();
        ex_valid_i = 1'b0;
        checks++; if ({dmem_req_o, exc_misaligned_o, mem_valid_o} !== 3'b011) begin errors++; $display("FAIL mis_flags: got req/exc/vld=%b want 011", {dmem_req_o, exc_misaligned_o, mem_valid_o}); end
        checks++; if (mem_control_o !== C_LDX || mem_readData_o !== 32'h0) begin errors++; $display("FAIL mis_ctrl: got %b %h want %b 0", mem_control_o, mem_readData_o, C_LDX); end
        tick();
        checks++; if ({exc_misaligned_o, mem_valid_o, ex_ready_o} !== 3'b010) begin errors++; $display("FAIL mis_stall: got exc/vld/rdy=%b want 010", {exc_misaligned_o, mem_valid_o, ex_ready_o}); end
        checks++; if (mem_aluResult_o !== 32'h101) begin errors++; $display("FAIL mis_stable: got %h want 00000101", mem_aluResult_o); end
        mem_ready_i = 1'b1;
        #1;
        checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b want 1", ex_ready_o); end
        tick();
        checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL mis_drain: got %b want 0", mem_valid_o); end
    endtask

    task automatic test_timeout();
        drive_ex(1'b1, I_LW, C_LD, 32'h200, 32'h0, 5'd4);
        tick();
        ex_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (dmem_req_o !== 1'b1 || exc_buserr_o !== 1'b0) begin errors++; $display("FAIL to_wait[%0d]: got req=%b exc=%b want 1 0", c, dmem_req_o, exc_buserr_o); end
            tick();
        end
        checks++; if ({dmem_req_o, exc_buserr_o, mem_valid_o} !== 3'b011) begin errors++; $display("FAIL to_fire: got req/exc/vld=%b want 011", {dmem_req_o, exc_buserr_o, mem_valid_o}); end
        checks++; if (mem_control_o !== C_LDX || mem_readData_o !== 32'h0) begin errors++; $display("FAIL to_ctrl: got %b %h want %b 0", mem_control_o, mem_readData_o, C_LDX); end
        tick();
        checks++; if (exc_buserr_o !== 1'b0 || mem_valid_o !== 1'b0) begin errors++; $display("FAIL to_pulse: got exc=%b vld=%b want 0 0", exc_buserr_o, mem_valid_o); end
    endtask

    task automatic test_reset_mid_resp();
        drive_ex(1'b1, I_LW, C_LD, 32'h300, 32'h0, 5'd5);
        tick();
        ex_valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        checks++; if (dmem_req_o !== 1'b0 || mem_valid_o !== 1'b0) begin errors++; $display("FAIL rst_in_resp: got req=%b vld=%b want 0 0", dmem_req_o, mem_valid_o); end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        checks++; if (ex_ready_o !== 1'b1 || mem_valid_o !== 1'b0) begin errors++; $display("FAIL rst_release: got rdy=%b vld=%b want 1 0", ex_ready_o, mem_valid_o); end
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid_i = 1'b0;
        checks++; if (mem_valid_o !== 1'b0 || mem_readData_o !== 32'h0) begin errors++; $display("FAIL rst_late_rvalid: got vld=%b %h want 0 0", mem_valid_o, mem_readData_o); end
        tick();
        checks++; if (mem_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin errors++; $display("FAIL rst_idle: got vld=%b rdy=%b want 0 1", mem_valid_o, ex_ready_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_ni        = 1'b0;
        mem_ready_i   = 1'b1;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        drive_ex(1'b0, 32'h0, '0, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_alu_back_to_back();
        test_store_byte();
        test_store_word_fast();
        test_load_half(I_LH, 32'hFFFF_8001, "lh");
        test_load_half(I_LHU, 32'h0000_8001, "lhu");
        test_misaligned();
        test_timeout();
        test_reset_mid_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
